// File: rtl/piso_shift_ctrl.sv
// piso_shift_ctrl: parallel-in / serial-out shift register with a load
// handshake, a bit counter and frame markers (last, done).
//
// Parameters
//   WIDTH     word width in bits (>= 2)
//   MSB_FIRST 1 = serial order MSB->LSB, 0 = LSB->MSB
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   data_in        parallel word, taken when load_valid && load_ready
//   load_valid     upstream word valid
//   load_ready     block accepts a word this cycle (combinational)
//   shift_en       downstream consumes the current bit; 0 = stall
//   serial_out     current serial bit
//   serial_valid   serial_out is a frame bit consumed this cycle
//   last           current bit is the final bit of the word
//   busy           a word is in flight
//   done           one-cycle pulse after the final bit is consumed

// One register bit: load/shift select mux plus its flop.
module piso_bit_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic ld_en,
  input  logic sh_en,
  input  logic clr,
  input  logic ld_bit,
  input  logic nb_bit,
  output logic q
);
  logic bit_d, bit_q;

  // load wins over everything; clr empties the register at end of frame
  always_comb begin
    bit_d = bit_q;
    if (ld_en)      bit_d = ld_bit;
    else if (clr)   bit_d = 1'b0;
    else if (sh_en) bit_d = nb_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bit_q <= 1'b0;
    else        bit_q <= bit_d;
  end

  assign q = bit_q;
endmodule

module piso_shift_ctrl #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             last,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           done_d, done_q;
  logic [WIDTH-1:0] sreg_q, nbr;
  logic           in_shift, at_last, load_fire, ld_en, sh_en, clr;

  assign in_shift  = (state_q == SHIFT);
  assign at_last   = in_shift && (cnt_q == CW'(WIDTH-1));
  // rst_n gate keeps ready low while reset is held even though state is IDLE
  assign load_ready = rst_n && (!in_shift || (at_last && shift_en));
  assign load_fire  = load_valid && load_ready;

  assign ld_en = load_fire;
  assign sh_en = in_shift && shift_en && !at_last;
  assign clr   = at_last && shift_en && !load_valid;

  // shifted neighbour per bit; the vacated end fills with 0
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      if (MSB_FIRST) begin : g_msb
        if (i == 0) begin : g_end
          assign nbr[i] = 1'b0;
        end else begin : g_mid
          assign nbr[i] = sreg_q[i-1];
        end
      end else begin : g_lsb
        if (i == WIDTH-1) begin : g_end
          assign nbr[i] = 1'b0;
        end else begin : g_mid
          assign nbr[i] = sreg_q[i+1];
        end
      end

      piso_bit_cell u_cell (
        .clk    (clk),
        .rst_n  (rst_n),
        .ld_en  (ld_en),
        .sh_en  (sh_en),
        .clr    (clr),
        .ld_bit (data_in[i]),
        .nb_bit (nbr[i]),
        .q      (sreg_q[i])
      );
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_fire) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (!at_last) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            done_d = 1'b1;
            cnt_d  = '0;
            // back-to-back: a waiting word is taken on the last-bit edge
            if (!load_valid) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy         = in_shift;
  assign serial_out   = in_shift && (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]);
  assign serial_valid = in_shift && shift_en;
  assign last         = at_last;
  assign done         = done_q;
endmodule
